// File: rtl/peak_detector_pkg.sv
// Shared constants and types for the pulse peak detector.
package peak_detector_pkg;

  localparam int SIZE_FILTER_DATA = 16;
  localparam int SIZE_TIMESTAMP   = 32;
  localparam int SIZE_PEAK_WIDTH  = 8;
  localparam int SIZE_HOLDOFF     = 8;
  localparam int SIZE_DROP_CNT    = 8;

  typedef enum logic [1:0] {
    PD_IDLE    = 2'd0,
    PD_ABOVE   = 2'd1,
    PD_HOLDOFF = 2'd2
  } pd_state_t;

  // One measured pulse, packed MSB-first as {amplitude, timestamp, width}.
  typedef struct packed {
    logic [SIZE_FILTER_DATA-1:0] amplitude;
    logic [SIZE_TIMESTAMP-1:0]   timestamp;
    logic [SIZE_PEAK_WIDTH-1:0]  width;
  } peak_record_t;

endpackage

// File: rtl/peak_out_reg.sv
// Single-entry output holding register for peak records.
//
// Handshake: o_valid stays high and o_rec stays stable until a cycle where
// o_valid & i_ready are both high; the record is consumed on that clock edge.
// A record offered on i_load while the slot is full and not being consumed
// is discarded, and o_drop_count counts it (saturating).
module peak_out_reg
  import peak_detector_pkg::*;
#(
  parameter int REC_W  = 56,
  parameter int DROP_W = SIZE_DROP_CNT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic [REC_W-1:0]  i_rec,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [REC_W-1:0]  o_rec,
  output logic [DROP_W-1:0] o_drop_count
);

  logic              r_valid;
  logic [REC_W-1:0]  r_rec;
  logic [DROP_W-1:0] r_drop_count;
  logic              w_slot_free;

  assign w_slot_free = !r_valid || i_ready;

  // Load into a free (or draining) slot, otherwise count the lost record.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_valid      <= 1'b0;
      r_rec        <= '0;
      r_drop_count <= '0;
    end else if (i_load) begin
      if (w_slot_free) begin
        r_valid <= 1'b1;
        r_rec   <= i_rec;
      end else if (r_drop_count != '1) begin
        r_drop_count <= r_drop_count + 1'b1;
      end
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid      = r_valid;
  assign o_rec        = r_rec;
  assign o_drop_count = r_drop_count;

endmodule

// File: rtl/peak_detector.sv
// Threshold pulse detector: measures peak amplitude, time of first maximum
// and width above threshold for each pulse, then applies a holdoff.
module peak_detector
  import peak_detector_pkg::*;
#(
  parameter int DATA_W    = SIZE_FILTER_DATA,
  parameter int TS_W      = SIZE_TIMESTAMP,
  parameter int WIDTH_W   = SIZE_PEAK_WIDTH,
  parameter int HOLDOFF_W = SIZE_HOLDOFF,
  parameter int DROP_W    = SIZE_DROP_CNT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_W-1:0]    input_data,
  input  logic [DATA_W-1:0]    threshold,
  input  logic [HOLDOFF_W-1:0] holdoff,
  input  logic                 peak_ready,
  output logic                 peak_valid,
  output logic [DATA_W-1:0]    peak_amplitude,
  output logic [TS_W-1:0]      peak_time,
  output logic [WIDTH_W-1:0]   peak_width,
  output logic [DROP_W-1:0]    drop_count,
  output logic                 busy,
  output pd_state_t            dbg_state
);

  localparam int REC_W = DATA_W + TS_W + WIDTH_W;

  logic [TS_W-1:0]      r_ts;
  logic [DATA_W-1:0]    r_s_data;
  logic [TS_W-1:0]      r_s_ts;
  pd_state_t            r_state;
  pd_state_t            w_next_state;
  logic [DATA_W-1:0]    r_thr;
  logic [DATA_W-1:0]    r_max;
  logic [TS_W-1:0]      r_max_ts;
  logic [WIDTH_W-1:0]   r_width;
  logic [HOLDOFF_W-1:0] r_hold_cnt;
  logic                 w_issue;
  logic [REC_W-1:0]     w_rec;
  logic [REC_W-1:0]     w_out_rec;

  // Free-running timestamp and one-cycle input register pairing each sample
  // with the time it arrived.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ts     <= '0;
      r_s_data <= '0;
      r_s_ts   <= '0;
    end else begin
      r_ts     <= r_ts + 1'b1;
      r_s_data <= input_data;
      r_s_ts   <= r_ts;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= PD_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode and event-complete strobe.
  always_comb begin
    w_next_state = r_state;
    w_issue      = 1'b0;
    case (r_state)
      PD_IDLE: begin
        if (r_s_data > threshold) w_next_state = PD_ABOVE;
      end
      PD_ABOVE: begin
        if (r_s_data <= r_thr) begin
          w_issue      = 1'b1;
          w_next_state = (holdoff != '0) ? PD_HOLDOFF : PD_IDLE;
        end
      end
      PD_HOLDOFF: begin
        if (r_hold_cnt == HOLDOFF_W'(1)) w_next_state = PD_IDLE;
      end
      default: w_next_state = PD_IDLE;
    endcase
  end

  // Event measurement: threshold is frozen at trigger, strict compare on the
  // maximum keeps the earliest of equal peaks, width saturates.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_thr      <= '0;
      r_max      <= '0;
      r_max_ts   <= '0;
      r_width    <= '0;
      r_hold_cnt <= '0;
    end else begin
      case (r_state)
        PD_IDLE: begin
          if (r_s_data > threshold) begin
            r_thr    <= threshold;
            r_max    <= r_s_data;
            r_max_ts <= r_s_ts;
            r_width  <= WIDTH_W'(1);
          end
        end
        PD_ABOVE: begin
          if (r_s_data > r_thr) begin
            if (r_width != '1) r_width <= r_width + 1'b1;
            if (r_s_data > r_max) begin
              r_max    <= r_s_data;
              r_max_ts <= r_s_ts;
            end
          end else begin
            r_hold_cnt <= holdoff;
          end
        end
        PD_HOLDOFF: begin
          r_hold_cnt <= r_hold_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign w_rec = {r_max, r_max_ts, r_width};

  peak_out_reg #(
    .REC_W  (REC_W),
    .DROP_W (DROP_W)
  ) u_out (
    .clk          (clk),
    .reset        (reset),
    .i_load       (w_issue),
    .i_rec        (w_rec),
    .i_ready      (peak_ready),
    .o_valid      (peak_valid),
    .o_rec        (w_out_rec),
    .o_drop_count (drop_count)
  );

  assign peak_amplitude = w_out_rec[REC_W-1 -: DATA_W];
  assign peak_time      = w_out_rec[WIDTH_W +: TS_W];
  assign peak_width     = w_out_rec[WIDTH_W-1:0];
  assign busy           = (r_state != PD_IDLE);
  assign dbg_state      = r_state;

endmodule

// File: tb/tb_peak_detector.sv
// Bench for peak_detector: scoreboard of expected records plus scenario tasks.
module tb_peak_detector;
  import peak_detector_pkg::*;

  localparam int REC_W = 16 + 32 + 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] input_data;
  logic [15:0] threshold;
  logic [7:0]  holdoff;
  logic        peak_ready;
  logic        peak_valid;
  logic [15:0] peak_amplitude;
  logic [31:0] peak_time;
  logic [7:0]  peak_width;
  logic [7:0]  drop_count;
  logic        busy;
  pd_state_t   dbg_state;

  // Second instance with a short timestamp so a wrap is reachable.
  logic        w_peak_valid;
  logic [15:0] w_peak_amplitude;
  logic [5:0]  w_peak_time;
  logic [7:0]  w_peak_width;
  logic [7:0]  w_drop_count;
  logic        w_busy;
  pd_state_t   w_dbg_state;

  int errors = 0;
  int checks = 0;
  logic [31:0]      m_ts = '0;
  logic [REC_W-1:0] exp_q[$];

  peak_detector dut (
    .clk(clk), .reset(reset), .input_data(input_data), .threshold(threshold),
    .holdoff(holdoff), .peak_ready(peak_ready), .peak_valid(peak_valid),
    .peak_amplitude(peak_amplitude), .peak_time(peak_time), .peak_width(peak_width),
    .drop_count(drop_count), .busy(busy), .dbg_state(dbg_state)
  );

  peak_detector #(.TS_W(6)) dut_w (
    .clk(clk), .reset(reset), .input_data(input_data), .threshold(threshold),
    .holdoff(holdoff), .peak_ready(1'b1), .peak_valid(w_peak_valid),
    .peak_amplitude(w_peak_amplitude), .peak_time(w_peak_time), .peak_width(w_peak_width),
    .drop_count(w_drop_count), .busy(w_busy), .dbg_state(w_dbg_state)
  );

  // clock / reset-aware timestamp model
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!reset) m_ts <= '0;
    else        m_ts <= m_ts + 1;
  end

  // scoreboard: compare each accepted record against the expected queue
  always @(negedge clk) begin
    logic [REC_W-1:0] exp_rec;
    if (reset === 1'b1 && peak_valid === 1'b1 && peak_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_record: got amp=%0d time=%0d width=%0d, none expected",
                 peak_amplitude, peak_time, peak_width);
      end else begin
        exp_rec = exp_q.pop_front();
        if ({peak_amplitude, peak_time, peak_width} !== exp_rec) begin
          errors++;
          $display("FAIL record: got amp=%0d time=%0d width=%0d, required amp=%0d time=%0d width=%0d",
                   peak_amplitude, peak_time, peak_width,
                   exp_rec[55:40], exp_rec[39:8], exp_rec[7:0]);
        end
      end
    end
  end

  // driver: present one sample, return its timestamp, step past the edge
  task automatic send(input logic [15:0] v, output logic [31:0] t);
    input_data = v;
    t = m_ts;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    logic [31:0] t;
    for (int i = 0; i < n; i++) send(16'd0, t);
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_pending: %0d records still outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; input_data = 16'd0; threshold = 16'd100; holdoff = 8'd0; peak_ready = 1'b1;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    checks++;
    if ({peak_valid, peak_amplitude, peak_time, peak_width, drop_count, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b amp=%0d time=%0d width=%0d drop=%0d busy=%b, required all 0",
               peak_valid, peak_amplitude, peak_time, peak_width, drop_count, busy);
    end
    checks++;
    if (dbg_state !== PD_IDLE) begin
      errors++;
      $display("FAIL reset_state: got %0d required %0d", dbg_state, PD_IDLE);
    end
    reset = 1'b1;
  endtask

  task automatic test_basic;
    logic [31:0] t;
    threshold = 16'd100; holdoff = 8'd0; peak_ready = 1'b1;
    while (m_ts != 32'd10) send(16'd0, t);
    send(16'd150, t);
    send(16'd300, t);
    send(16'd200, t);
    exp_q.push_back({16'd300, 32'd11, 8'd3});
    send(16'd50, t);
    @(negedge clk);
    checks++;
    if (peak_valid !== 1'b0) begin
      errors++; $display("FAIL basic_valid_early: got %b required 0", peak_valid);
    end
    send(16'd0, t);
    @(negedge clk);
    checks++;
    if (peak_valid !== 1'b1) begin
      errors++; $display("FAIL basic_valid_rise: got %b required 1", peak_valid);
    end
    send(16'd0, t);
    @(negedge clk);
    checks++;
    if (peak_valid !== 1'b0) begin
      errors++; $display("FAIL basic_valid_fall: got %b required 0", peak_valid);
    end
    idle(3);
    check_drained("basic");
  endtask

  task automatic test_plateau;
    logic [31:0] t, tpk;
    threshold = 16'd100; holdoff = 8'd0; peak_ready = 1'b1;
    send(16'd0, t);
    send(16'd200, t);
    send(16'd250, tpk);
    send(16'd250, t);
    send(16'd250, t);
    exp_q.push_back({16'd250, tpk, 8'd4});
    send(16'd0, t);
    idle(4);
    check_drained("plateau");
    send(16'd100, t);
    send(16'd0, t);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || peak_valid !== 1'b0) begin
      errors++; $display("FAIL equal_threshold: got busy=%b valid=%b required 0 0", busy, peak_valid);
    end
    idle(3);
    check_drained("equal_threshold");
  endtask

  task automatic test_holdoff;
    logic [31:0] t, ta, tb;
    threshold = 16'd100; holdoff = 8'd5; peak_ready = 1'b1;
    // second pulse starts 3 cycles after the first sub-threshold sample
    send(16'd200, t);
    send(16'd300, ta);
    exp_q.push_back({16'd300, ta, 8'd2});
    send(16'd50, t);
    idle(2);
    send(16'd200, t);
    send(16'd210, t);
    send(16'd220, t);
    send(16'd400, tb);
    send(16'd230, t);
    send(16'd240, t);
    exp_q.push_back({16'd400, tb, 8'd3});
    send(16'd0, t);
    idle(10);
    check_drained("holdoff_overlap");
    // second pulse starts 6 cycles after: both pulses are whole events
    send(16'd200, t);
    send(16'd300, ta);
    exp_q.push_back({16'd300, ta, 8'd2});
    send(16'd50, t);
    idle(5);
    send(16'd220, t);
    send(16'd330, tb);
    send(16'd260, t);
    exp_q.push_back({16'd330, tb, 8'd3});
    send(16'd0, t);
    idle(10);
    check_drained("holdoff_clear");
  endtask

  task automatic test_backpressure;
    logic [31:0] t, t1;
    threshold = 16'd100; holdoff = 8'd0; peak_ready = 1'b0;
    send(16'd150, t1); send(16'd0, t); idle(3);
    send(16'd250, t);  send(16'd0, t); idle(3);
    send(16'd350, t);  send(16'd0, t); idle(3);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if ({peak_valid, peak_amplitude, peak_time, peak_width} !== {1'b1, 16'd150, t1, 8'd1}) begin
        errors++;
        $display("FAIL held_record: got valid=%b amp=%0d time=%0d width=%0d, required 1 150 %0d 1",
                 peak_valid, peak_amplitude, peak_time, peak_width, t1);
      end
      idle(1);
    end
    checks++;
    if (drop_count !== 8'd2) begin
      errors++; $display("FAIL drop_count: got %0d required 2", drop_count);
    end
    exp_q.push_back({16'd150, t1, 8'd1});
    peak_ready = 1'b1;
    idle(1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (peak_valid !== 1'b0) begin
        errors++; $display("FAIL after_accept_valid: got %b required 0", peak_valid);
      end
      idle(1);
    end
    checks++;
    if (drop_count !== 8'd2) begin
      errors++; $display("FAIL drop_count_hold: got %0d required 2", drop_count);
    end
    check_drained("backpressure");
  endtask

  task automatic test_width_sat;
    logic [31:0] t, tpk;
    threshold = 16'd100; holdoff = 8'd0; peak_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (i == 260) send(16'd500, tpk);
      else          send(16'd200, t);
    end
    exp_q.push_back({16'd500, tpk, 8'd255});
    send(16'd0, t);
    idle(4);
    check_drained("width_sat");
  endtask

  task automatic test_ts_wrap;
    logic [31:0] t, tpk;
    bit seen;
    threshold = 16'd100; holdoff = 8'd0; peak_ready = 1'b1;
    seen = 1'b0;
    while (m_ts[5:0] != 6'd62) send(16'd0, t);
    send(16'd150, t);
    send(16'd300, t);
    send(16'd400, tpk);
    send(16'd350, t);
    exp_q.push_back({16'd400, tpk, 8'd4});
    send(16'd50, t);
    for (int i = 0; i < 6 && !seen; i++) begin
      @(negedge clk);
      if (w_peak_valid === 1'b1) begin
        seen = 1'b1;
        checks++;
        if ({w_peak_amplitude, w_peak_time, w_peak_width} !== {16'd400, 6'd0, 8'd4}) begin
          errors++;
          $display("FAIL ts_wrap: got amp=%0d time=%0d width=%0d, required 400 0 4",
                   w_peak_amplitude, w_peak_time, w_peak_width);
        end
      end else begin
        send(16'd0, t);
      end
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL ts_wrap_timeout: got no record in 6 cycles, required one");
    end
    idle(3);
    check_drained("ts_wrap");
  endtask

  task automatic test_reset_mid_event;
    logic [31:0] t;
    threshold = 16'd100; holdoff = 8'd0; peak_ready = 1'b0;
    send(16'd150, t); send(16'd0, t); idle(2);
    send(16'd200, t);
    send(16'd300, t);
    reset = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({peak_valid, peak_amplitude, peak_time, peak_width, drop_count, busy} !== '0) begin
      errors++;
      $display("FAIL mid_event_reset: got valid=%b amp=%0d time=%0d width=%0d drop=%0d busy=%b, required all 0",
               peak_valid, peak_amplitude, peak_time, peak_width, drop_count, busy);
    end
    reset = 1'b1;
    peak_ready = 1'b1;
    send(16'd50, t);
    for (int i = 0; i < 5; i++) begin
      send(16'd0, t);
      @(negedge clk);
      checks++;
      if (peak_valid !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL post_reset_quiet: got valid=%b busy=%b required 0 0", peak_valid, busy);
      end
    end
    check_drained("reset_mid_event");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_plateau();
    test_holdoff();
    test_backpressure();
    test_width_sat();
    test_ts_wrap();
    test_reset_mid_event();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
